saturn_bus_arbiter: RTL and testbench

Sequencer and arbiter that shares the single Saturn nibble bus between the instruction-fetch unit and the data-memory unit. Drives the bus command sequence on the bus lines: pointer-load command, 5 address nibbles, transfer command, then data nibbles. It grants one requester at a time and returns fetched or loaded nibbles. It sits between the core's fetch/load-store logic and the bus pins.

---
 rtl/saturn_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_saturn_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_bus_arbiter.sv
// Saturn nibble-bus sequencer/arbiter: shares the bus between instruction fetch and data memory.
// Optional PC shadow (skips LOAD_PC + address on sequential fetches): `SATURN_BUS_PC_TRACK_EN.
module saturn_bus_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_req,
  input  logic [19:0] i_f_addr,
  output logic        o_f_grant,
  output logic [3:0]  o_f_nibble,
  output logic        o_f_valid,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [19:0] i_d_addr,
  input  logic [3:0]  i_d_len,
  input  logic [63:0] i_d_wdata,
  output logic        o_d_grant,
  output logic [63:0] o_d_rdata,
  output logic        o_d_done,
  input  logic [3:0]  i_bus_data,
  output logic [3:0]  o_bus_data,
  output logic        o_bus_strobe,
  output logic        o_bus_cmd_data
);

  // Bus command codes (def-buscmd.v)
  localparam logic [3:0] BusCmdPcRead  = 4'h2;
  localparam logic [3:0] BusCmdDpRead  = 4'h3;
  localparam logic [3:0] BusCmdDpWrite = 4'h5;
  localparam logic [3:0] BusCmdLoadPc  = 4'h6;
  localparam logic [3:0] BusCmdLoadDp  = 4'h7;

  typedef enum logic [2:0] {StIdle, StLoad, StAddr, StXfer, StData} state_e;

  state_e      state_q, state_d;
  logic [2:0]  acnt_q, acnt_d;
  logic [3:0]  nib_q, nib_d;
  logic [19:0] addr_q, addr_d;
  logic        data_own_q, data_own_d;
  logic        we_q, we_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] wdata_q, wdata_d;

  logic [3:0]  bus_data_q, bus_data_d;
  logic        strobe_q, strobe_d;
  logic        cmd_data_q, cmd_data_d;
  logic        f_grant_q, f_grant_d;
  logic        d_grant_q, d_grant_d;
  logic [3:0]  f_nibble_q, f_nibble_d;
  logic        f_valid_q, f_valid_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        d_done_q, d_done_d;

  logic        pc_hit;
  logic        fetch_end;
  logic [3:0]  xfer_cmd;

  assign xfer_cmd = data_own_q ? (we_q ? BusCmdDpWrite : BusCmdDpRead) : BusCmdPcRead;

  // Outputs are registered, so each branch computes what the next cycle drives.
  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    nib_d      = nib_q;
    addr_d     = addr_q;
    data_own_d = data_own_q;
    we_d       = we_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    bus_data_d = 4'h0;
    strobe_d   = 1'b0;
    cmd_data_d = 1'b1;
    f_grant_d  = 1'b0;
    d_grant_d  = 1'b0;
    f_nibble_d = f_nibble_q;
    f_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_done_d   = 1'b0;
    fetch_end  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_d_req) begin
          state_d    = StLoad;
          data_own_d = 1'b1;
          addr_d     = i_d_addr;
          we_d       = i_d_we;
          len_d      = i_d_len;
          wdata_d    = i_d_wdata;
          d_rdata_d  = '0;
          strobe_d   = 1'b1;
          cmd_data_d = 1'b0;
          bus_data_d = BusCmdLoadDp;
        end else if (i_f_req) begin
          data_own_d = 1'b0;
          addr_d     = i_f_addr;
          strobe_d   = 1'b1;
          cmd_data_d = 1'b0;
          if (pc_hit) begin
            state_d    = StXfer;
            bus_data_d = BusCmdPcRead;
          end else begin
            state_d    = StLoad;
            bus_data_d = BusCmdLoadPc;
          end
        end
      end
      StLoad: begin
        state_d    = StAddr;
        acnt_d     = 3'd0;
        strobe_d   = 1'b1;
        cmd_data_d = 1'b0;
        bus_data_d = addr_q[3:0];
      end
      StAddr: begin
        strobe_d   = 1'b1;
        cmd_data_d = 1'b0;
        if (acnt_q == 3'd4) begin
          state_d    = StXfer;
          bus_data_d = xfer_cmd;
        end else begin
          acnt_d     = acnt_q + 3'd1;
          bus_data_d = addr_q[{acnt_d, 2'b00} +: 4];
        end
      end
      StXfer: begin
        if (data_own_q || (i_f_req && !i_d_req)) begin
          state_d    = StData;
          nib_d      = 4'd0;
          strobe_d   = 1'b1;
          bus_data_d = (data_own_q && we_q) ? wdata_q[3:0] : 4'h0;
        end else begin
          state_d   = StIdle;
          fetch_end = 1'b1;
        end
      end
      StData: begin
        addr_d = addr_q + 20'd1;
        if (data_own_q) begin
          if (!we_q) d_rdata_d[{nib_q, 2'b00} +: 4] = i_bus_data;
          if (nib_q == len_q) begin
            state_d  = StIdle;
            d_done_d = 1'b1;
          end else begin
            nib_d      = nib_q + 4'd1;
            strobe_d   = 1'b1;
            bus_data_d = we_q ? wdata_q[{nib_d, 2'b00} +: 4] : 4'h0;
          end
        end else begin
          f_nibble_d = i_bus_data;
          f_valid_d  = 1'b1;
          if (i_f_req && !i_d_req) begin
            strobe_d = 1'b1;
          end else begin
            state_d   = StIdle;
            fetch_end = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every owned cycle strobes the bus, so grant follows the strobe.
    if (strobe_d) begin
      f_grant_d = ~data_own_d;
      d_grant_d = data_own_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      acnt_q     <= 3'd0;
      nib_q      <= 4'd0;
      addr_q     <= '0;
      data_own_q <= 1'b0;
      we_q       <= 1'b0;
      len_q      <= 4'd0;
      wdata_q    <= '0;
      bus_data_q <= 4'h0;
      strobe_q   <= 1'b0;
      cmd_data_q <= 1'b1;
      f_grant_q  <= 1'b0;
      d_grant_q  <= 1'b0;
      f_nibble_q <= 4'h0;
      f_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acnt_q     <= acnt_d;
      nib_q      <= nib_d;
      addr_q     <= addr_d;
      data_own_q <= data_own_d;
      we_q       <= we_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      bus_data_q <= bus_data_d;
      strobe_q   <= strobe_d;
      cmd_data_q <= cmd_data_d;
      f_grant_q  <= f_grant_d;
      d_grant_q  <= d_grant_d;
      f_nibble_q <= f_nibble_d;
      f_valid_q  <= f_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_done_q   <= d_done_d;
    end
  end

`ifdef SATURN_BUS_PC_TRACK_EN
  logic [19:0] pc_shadow_q;
  logic        pc_valid_q;

  assign pc_hit = pc_valid_q && (i_f_addr == pc_shadow_q);

  // addr_d already includes the nibble strobed in the final data cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_valid_q  <= 1'b0;
      pc_shadow_q <= '0;
    end else if (fetch_end) begin
      pc_valid_q  <= 1'b1;
      pc_shadow_q <= addr_d;
    end
  end
`else
  logic unused_fetch_end;

  assign pc_hit           = 1'b0;
  assign unused_fetch_end = fetch_end;
`endif

  assign o_bus_data     = bus_data_q;
  assign o_bus_strobe   = strobe_q;
  assign o_bus_cmd_data = cmd_data_q;
  assign o_f_grant      = f_grant_q;
  assign o_d_grant      = d_grant_q;
  assign o_f_nibble     = f_nibble_q;
  assign o_f_valid      = f_valid_q;
  assign o_d_rdata      = d_rdata_q;
  assign o_d_done       = d_done_q;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Scoreboard bench for saturn_bus_arbiter: driver tasks push expected bus strobes, fetched
// nibbles and data completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_saturn_bus_arbiter;

  localparam logic [3:0] CmdPcRead  = 4'h2;
  localparam logic [3:0] CmdDpRead  = 4'h3;
  localparam logic [3:0] CmdDpWrite = 4'h5;
  localparam logic [3:0] CmdLoadPc  = 4'h6;
  localparam logic [3:0] CmdLoadDp  = 4'h7;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_f_req;
  logic [19:0] i_f_addr;
  logic        o_f_grant;
  logic [3:0]  o_f_nibble;
  logic        o_f_valid;
  logic        i_d_req;
  logic        i_d_we;
  logic [19:0] i_d_addr;
  logic [3:0]  i_d_len;
  logic [63:0] i_d_wdata;
  logic        o_d_grant;
  logic [63:0] o_d_rdata;
  logic        o_d_done;
  logic [3:0]  i_bus_data;
  logic [3:0]  o_bus_data;
  logic        o_bus_strobe;
  logic        o_bus_cmd_data;

  saturn_bus_arbiter dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_f_req        (i_f_req),
    .i_f_addr       (i_f_addr),
    .o_f_grant      (o_f_grant),
    .o_f_nibble     (o_f_nibble),
    .o_f_valid      (o_f_valid),
    .i_d_req        (i_d_req),
    .i_d_we         (i_d_we),
    .i_d_addr       (i_d_addr),
    .i_d_len        (i_d_len),
    .i_d_wdata      (i_d_wdata),
    .o_d_grant      (o_d_grant),
    .o_d_rdata      (o_d_rdata),
    .o_d_done       (o_d_done),
    .i_bus_data     (i_bus_data),
    .o_bus_data     (o_bus_data),
    .o_bus_strobe   (o_bus_strobe),
    .o_bus_cmd_data (o_bus_cmd_data)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         c;
    logic       cd;
    logic [3:0] d;
    logic       chkd;
    logic       f;
  } strobe_t;
  typedef struct {
    int         c;
    logic [3:0] n;
  } fv_t;
  typedef struct {
    int          c;
    logic [63:0] r;
  } dn_t;

  strobe_t sq[$];
  fv_t     fq[$];
  dn_t     dq[$];

  logic [3:0]  busmem [0:4095];
  bit          mon_en = 1'b0;
  bit          sh_valid = 1'b0;
  logic [19:0] sh_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s @cycle %0d: DUT pulsed with nothing expected", name, cyc);
  endtask

  // Bus slave: a fresh random nibble every cycle, so a capture on the wrong edge is visible.
  initial begin
    for (int i = 0; i < 4096; i++) busmem[i] = 4'($urandom);
    forever begin
      @(negedge i_clk);
      i_bus_data = busmem[cyc % 4096];
    end
  end

  initial begin
    strobe_t s;
    fv_t     v;
    dn_t     d;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_bus_strobe) begin
          if (sq.size() == 0) unexpected("bus_strobe");
          else begin
            s = sq.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(s.c));
            chk("bus_cmd_data", 64'(o_bus_cmd_data), 64'(s.cd));
            if (s.chkd) chk("bus_data", 64'(o_bus_data), 64'(s.d));
            chk("grants", 64'({o_f_grant, o_d_grant}), 64'({s.f, !s.f}));
          end
        end else begin
          chk("idle_bus", 64'({o_bus_cmd_data, o_bus_data, o_f_grant, o_d_grant}),
              64'({1'b1, 4'h0, 2'b00}));
        end
        if (o_f_valid) begin
          if (fq.size() == 0) unexpected("f_valid");
          else begin
            v = fq.pop_front();
            chk("f_valid_cycle", 64'(cyc), 64'(v.c));
            chk("f_nibble", 64'(o_f_nibble), 64'(v.n));
          end
        end
        if (o_d_done) begin
          if (dq.size() == 0) unexpected("d_done");
          else begin
            d = dq.pop_front();
            chk("d_done_cycle", 64'(cyc), 64'(d.c));
            chk("d_rdata", o_d_rdata, d.r);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic wait_cycle(input int c);
    if (cyc > c) begin
      $display("FAIL schedule: at cycle %0d, required cycle %0d", cyc, c);
      $fatal(1);
    end
    while (cyc < c) @(negedge i_clk);
  endtask

  task automatic push_strobe(input int c, input logic cd, input logic [3:0] d,
                             input logic chkd, input logic f);
    strobe_t s;
    s.c = c; s.cd = cd; s.d = d; s.chkd = chkd; s.f = f;
    sq.push_back(s);
  endtask

  task automatic check_reset_values();
    chk("reset_outputs",
        64'({o_bus_data, o_bus_strobe, o_bus_cmd_data, o_f_nibble, o_f_valid, o_f_grant,
             o_d_grant, o_d_done}),
        64'({4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}));
    chk("reset_rdata", o_d_rdata, 64'h0);
  endtask

  // Fetch of L nibbles requested in IDLE cycle c0; ends by dropping f_req or by raising d_req.
  task automatic run_fetch(input int c0, input logic [19:0] a, input int L, input bit stop_by_d,
                           output int nxt);
    int x;
    bit hit;
    fv_t v;
    wait_cycle(c0);
    i_f_req  = 1'b1;
    i_f_addr = a;
    hit = sh_valid && (sh_addr == a);
    if (hit) begin
      x = c0 + 1;
    end else begin
      push_strobe(c0 + 1, 1'b0, CmdLoadPc, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) push_strobe(c0 + 2 + k, 1'b0, 4'(a >> (4 * k)), 1'b1, 1'b1);
      x = c0 + 7;
    end
    push_strobe(x, 1'b0, CmdPcRead, 1'b1, 1'b1);
    for (int k = 0; k < L; k++) begin
      push_strobe(x + 1 + k, 1'b1, 4'h0, 1'b0, 1'b1);
      v.c = x + 2 + k;
      v.n = busmem[(x + 1 + k) % 4096];
      fq.push_back(v);
    end
    wait_cycle(x + L);
    if (stop_by_d) i_d_req = 1'b1;
    else i_f_req = 1'b0;
`ifdef SATURN_BUS_PC_TRACK_EN
    sh_valid = 1'b1;
    sh_addr  = a + 20'(L);
`endif
    nxt = x + L + 1;
  endtask

  task automatic run_data(input int c0, input logic we, input logic [19:0] a,
                          input logic [3:0] len, input logic [63:0] wd, output int nxt);
    int n;
    dn_t d;
    wait_cycle(c0);
    i_d_req   = 1'b1;
    i_d_we    = we;
    i_d_addr  = a;
    i_d_len   = len;
    i_d_wdata = wd;
    push_strobe(c0 + 1, 1'b0, CmdLoadDp, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) push_strobe(c0 + 2 + k, 1'b0, 4'(a >> (4 * k)), 1'b1, 1'b0);
    push_strobe(c0 + 7, 1'b0, we ? CmdDpWrite : CmdDpRead, 1'b1, 1'b0);
    n = int'(len) + 1;
    d.r = '0;
    for (int k = 0; k < n; k++) begin
      push_strobe(c0 + 8 + k, 1'b1, 4'(wd >> (4 * k)), we, 1'b0);
      if (!we) d.r = d.r | (64'(busmem[(c0 + 8 + k) % 4096]) << (4 * k));
    end
    d.c = c0 + 8 + n;
    dq.push_back(d);
    wait_cycle(c0 + 1);
    i_d_req = 1'b0;
    nxt = c0 + 8 + n;
  endtask

  initial begin
    int c;
    i_reset   = 1'b1;
    i_f_req   = 1'b0;
    i_f_addr  = '0;
    i_d_req   = 1'b0;
    i_d_we    = 1'b0;
    i_d_addr  = '0;
    i_d_len   = '0;
    i_d_wdata = '0;
    @(negedge i_clk);
    wait_cycle(3);
    check_reset_values();
    mon_en  = 1'b1;
    i_reset = 1'b0;
    c = 5;

    run_fetch(c, 20'h12345, 4, 1'b0, c);
    run_data(c, 1'b1, 20'hFFFFE, 4'd2, 64'h0000_0000_0000_0ABC, c);
    run_data(c, 1'b0, 20'h0ABCD, 4'd15, 64'h0, c);
    run_data(c, 1'b0, 20'h00010, 4'd0, 64'h0, c);

    // Both requests in the same IDLE cycle: data first, fetch after its done cycle.
    wait_cycle(c);
    i_f_req  = 1'b1;
    i_f_addr = 20'h55555;
    run_data(c, 1'b0, 20'h01234, 4'd3, 64'h0, c);
    run_fetch(c, 20'h55555, 2, 1'b0, c);

    // Data request arriving mid-burst cuts the fetch short.
    run_fetch(c + 1, 20'h00ABC, 3, 1'b1, c);
    run_data(c, 1'b1, 20'h77777, 4'd1, 64'h0000_0000_0000_005A, c);
    i_f_req = 1'b0;

    run_fetch(c + 2, 20'h00100, 3, 1'b0, c);
    run_fetch(c, 20'h00103, 2, 1'b0, c);
    run_fetch(c, 20'h00200, 1, 1'b0, c);
    run_fetch(c + 1, 20'hFFFFE, 4, 1'b0, c);
    run_fetch(c, 20'h00002, 1, 1'b0, c);
    run_fetch(c, 20'h00300, 2, 1'b0, c);
    run_data(c, 1'b0, 20'h00300, 4'd4, 64'h0, c);
    run_fetch(c, 20'h00302, 1, 1'b0, c);
    run_fetch(c, 20'h00400, 2, 1'b0, c);

    // Reset in ADDR aborts the data transaction and invalidates the PC shadow.
    c = c + 1;
    wait_cycle(c);
    i_d_req  = 1'b1;
    i_d_we   = 1'b0;
    i_d_addr = 20'hC0DE5;
    i_d_len  = 4'd3;
    push_strobe(c + 1, 1'b0, CmdLoadDp, 1'b1, 1'b0);
    push_strobe(c + 2, 1'b0, 4'h5, 1'b1, 1'b0);
    push_strobe(c + 3, 1'b0, 4'hE, 1'b1, 1'b0);
    wait_cycle(c + 1);
    i_d_req = 1'b0;
    wait_cycle(c + 3);
    i_reset = 1'b1;
    wait_cycle(c + 4);
    check_reset_values();
    i_reset  = 1'b0;
    sh_valid = 1'b0;
    run_fetch(c + 5, 20'h00402, 2, 1'b0, c);
    run_data(c, 1'b0, 20'hC0DE5, 4'd3, 64'h0, c);

    for (int t = 0; t < 40; t++) begin
      c = c + int'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) begin
        run_fetch(c, (sh_valid && $urandom_range(0, 1) == 1) ? sh_addr : 20'($urandom),
                  int'($urandom_range(1, 6)), 1'b0, c);
      end else begin
        run_data(c, 1'($urandom), 20'($urandom), 4'($urandom),
                 {32'($urandom), 32'($urandom)}, c);
      end
    end

    wait_cycle(c + 4);
    chk("strobe_queue_drained", 64'(sq.size()), 64'h0);
    chk("f_valid_queue_drained", 64'(fq.size()), 64'h0);
    chk("d_done_queue_drained", 64'(dq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
